// File: rtl/icache_control.sv
// icache_control
//   Sequencing FSM for a two-way, eight-set instruction cache. A lookup in IDLE
//   either hits and responds in the same cycle, or misses. A miss latches a
//   victim way, holds pmem_read until memory answers, loads data, tag and valid
//   in one cycle, then replays the lookup in RESPOND to answer the CPU.
//   It also keeps saturating hit/miss counters and a sticky multi-hit flag.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   mem_read / mem_resp  : CPU fetch request / completion
//   pmem_read/pmem_resp  : line-fill request / memory data valid
//   hit_datapath         : per-way tag match from the datapath
//   valid_out, lru_output: valid bits and LRU way of the indexed set
//   write_enable_0/1     : data-array load per way
//   load_tag, load_valid : tag/valid array load per way; set_valid mirrors load_valid
//   load_lru, set_lru    : LRU array load and the value written (way not used)
//   data_array_select    : fill-source select, high while fetching
//   hit_count/miss_count : saturating performance counters
//   err_multi_hit        : sticky, set when both ways match on a request
module icache_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    output logic                 mem_resp,
    input  logic                 pmem_resp,
    output logic                 pmem_read,
    input  logic [1:0]           hit_datapath,
    input  logic [1:0]           valid_out,
    input  logic                 lru_output,
    output logic                 write_enable_0,
    output logic                 write_enable_1,
    output logic [1:0]           load_tag,
    output logic [1:0]           load_valid,
    output logic [1:0]           set_valid,
    output logic                 load_lru,
    output logic                 set_lru,
    output logic                 data_array_select,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic                 err_multi_hit
);

    typedef enum logic [1:0] {IDLE, FETCH, RESPOND} state_t;

    state_t state, state_next;
    logic   victim, victim_next;
    logic   hit_inc, miss_inc, multi_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            victim        <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
            err_multi_hit <= 1'b0;
        end else begin
            state  <= state_next;
            victim <= victim_next;
            if (hit_inc && (hit_count != '1))
                hit_count <= hit_count + 1'b1;
            if (miss_inc && (miss_count != '1))
                miss_count <= miss_count + 1'b1;
            if (multi_hit)
                err_multi_hit <= 1'b1;
        end
    end

    always_comb begin
        state_next        = state;
        victim_next       = victim;
        hit_inc           = 1'b0;
        miss_inc          = 1'b0;
        multi_hit         = 1'b0;
        mem_resp          = 1'b0;
        pmem_read         = 1'b0;
        write_enable_0    = 1'b0;
        write_enable_1    = 1'b0;
        load_tag          = 2'b00;
        load_valid        = 2'b00;
        load_lru          = 1'b0;
        set_lru           = 1'b0;
        data_array_select = 1'b0;

        // Everything stays at defaults during reset so no array is disturbed.
        if (!rst) begin
            // Both ways matching means the tag array is corrupt; flag it.
            multi_hit = mem_read && (hit_datapath == 2'b11);
            unique case (state)
                IDLE: begin
                    if (mem_read) begin
                        unique case (hit_datapath)
                            // A multi-hit is resolved as a way-0 hit.
                            2'b01, 2'b11: begin
                                mem_resp = 1'b1;
                                load_lru = 1'b1;
                                set_lru  = 1'b1;
                                hit_inc  = 1'b1;
                            end
                            2'b10: begin
                                mem_resp = 1'b1;
                                load_lru = 1'b1;
                                set_lru  = 1'b0;
                                hit_inc  = 1'b1;
                            end
                            default: begin
                                miss_inc = 1'b1;
                                // Prefer an empty way before evicting the LRU one.
                                if (!valid_out[0])      victim_next = 1'b0;
                                else if (!valid_out[1]) victim_next = 1'b1;
                                else                    victim_next = lru_output;
                                state_next = FETCH;
                            end
                        endcase
                    end
                end
                FETCH: begin
                    // The fill is never aborted, even if the CPU drops mem_read.
                    pmem_read         = 1'b1;
                    data_array_select = 1'b1;
                    if (pmem_resp) begin
                        write_enable_0 = ~victim;
                        write_enable_1 = victim;
                        load_tag       = victim ? 2'b10 : 2'b01;
                        load_valid     = victim ? 2'b10 : 2'b01;
                        state_next     = RESPOND;
                    end
                end
                RESPOND: begin
                    // Replayed lookup hits the just-filled way; not counted as a hit.
                    if (mem_read) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        set_lru  = ~victim;
                    end
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign set_valid = load_valid;

endmodule

// File: tb/tb_icache_control.sv
module tb_icache_control;

  localparam int CW = 4;
  localparam int TIMEOUT_CYC = 2000;

  logic          clk = 1'b0;
  logic          rst, mem_read, pmem_resp, lru_output;
  logic [1:0]    hit_datapath, valid_out;
  logic          mem_resp, pmem_read, write_enable_0, write_enable_1;
  logic [1:0]    load_tag, load_valid, set_valid;
  logic          load_lru, set_lru, data_array_select, err_multi_hit;
  logic [CW-1:0] hit_count, miss_count;

  icache_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_resp(mem_resp),
    .pmem_resp(pmem_resp), .pmem_read(pmem_read), .hit_datapath(hit_datapath),
    .valid_out(valid_out), .lru_output(lru_output),
    .write_enable_0(write_enable_0), .write_enable_1(write_enable_1),
    .load_tag(load_tag), .load_valid(load_valid), .set_valid(set_valid),
    .load_lru(load_lru), .set_lru(set_lru), .data_array_select(data_array_select),
    .hit_count(hit_count), .miss_count(miss_count), .err_multi_hit(err_multi_hit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst, mr, pr;
    logic [1:0] hit, valid;
    logic       lru;
  } in_t;

  typedef struct packed {
    logic          resp, pread, we0, we1;
    logic [1:0]    lt, lv, sv;
    logic          ll, sl, das, err;
    logic [CW-1:0] hc, mc;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  function automatic in_t mk_in(bit r, bit mr, bit pr, bit [1:0] hit, bit [1:0] valid, bit lru);
    in_t x;
    x.rst = r; x.mr = mr; x.pr = pr; x.hit = hit; x.valid = valid; x.lru = lru;
    return x;
  endfunction

  function automatic out_t mk_out(bit resp, bit pread, bit [1:0] fill, bit ll, bit sl,
                                  bit das, bit err, int hc, int mc);
    out_t x;
    x.resp = resp; x.pread = pread; x.we0 = fill[0]; x.we1 = fill[1];
    x.lt = fill; x.lv = fill; x.sv = fill;
    x.ll = ll; x.sl = sl; x.das = das; x.err = err;
    x.hc = CW'(hc); x.mc = CW'(mc);
    return x;
  endfunction

  task automatic add(in_t i, out_t o);
    vec_t v;
    v.i = i; v.o = o;
    vecs.push_back(v);
  endtask

  function automatic out_t sample();
    out_t x;
    x.resp = mem_resp; x.pread = pmem_read; x.we0 = write_enable_0; x.we1 = write_enable_1;
    x.lt = load_tag; x.lv = load_valid; x.sv = set_valid;
    x.ll = load_lru; x.sl = set_lru; x.das = data_array_select; x.err = err_multi_hit;
    x.hc = hit_count; x.mc = miss_count;
    return x;
  endfunction

  initial begin
    repeat (TIMEOUT_CYC) @(posedge clk);
    if (!done) begin
      errors++;
      $display("FAIL timeout: vector sequence did not finish within %0d cycles", TIMEOUT_CYC);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    add(mk_in(1,1,1,2'b00,2'b00,0), mk_out(0,0,2'b00,0,0,0,0,0,0));
    add(mk_in(0,1,0,2'b00,2'b00,0), mk_out(0,0,2'b00,0,0,0,0,0,0));
    add(mk_in(0,1,0,2'b00,2'b00,0), mk_out(0,1,2'b00,0,0,1,0,0,1));
    add(mk_in(0,1,0,2'b00,2'b00,0), mk_out(0,1,2'b00,0,0,1,0,0,1));
    add(mk_in(0,1,0,2'b00,2'b00,0), mk_out(0,1,2'b00,0,0,1,0,0,1));
    add(mk_in(0,1,1,2'b00,2'b00,0), mk_out(0,1,2'b01,0,0,1,0,0,1));
    add(mk_in(0,1,0,2'b01,2'b01,0), mk_out(1,0,2'b00,1,1,0,0,0,1));
    add(mk_in(0,1,0,2'b01,2'b01,0), mk_out(1,0,2'b00,1,1,0,0,0,1));
    add(mk_in(0,0,0,2'b00,2'b01,0), mk_out(0,0,2'b00,0,0,0,0,1,1));
    add(mk_in(0,1,0,2'b00,2'b11,1), mk_out(0,0,2'b00,0,0,0,0,1,1));
    add(mk_in(0,1,1,2'b00,2'b11,1), mk_out(0,1,2'b10,0,0,1,0,1,2));
    add(mk_in(0,1,0,2'b10,2'b11,1), mk_out(1,0,2'b00,1,0,0,0,1,2));
    add(mk_in(0,1,0,2'b00,2'b01,0), mk_out(0,0,2'b00,0,0,0,0,1,2));
    add(mk_in(0,1,1,2'b00,2'b01,0), mk_out(0,1,2'b10,0,0,1,0,1,3));
    add(mk_in(0,1,0,2'b10,2'b11,0), mk_out(1,0,2'b00,1,0,0,0,1,3));
    add(mk_in(0,1,0,2'b00,2'b10,1), mk_out(0,0,2'b00,0,0,0,0,1,3));
    add(mk_in(0,1,1,2'b00,2'b10,1), mk_out(0,1,2'b01,0,0,1,0,1,4));
    add(mk_in(0,1,0,2'b01,2'b11,1), mk_out(1,0,2'b00,1,1,0,0,1,4));
    add(mk_in(0,1,0,2'b00,2'b11,0), mk_out(0,0,2'b00,0,0,0,0,1,4));
    add(mk_in(0,1,0,2'b00,2'b11,0), mk_out(0,1,2'b00,0,0,1,0,1,5));
    add(mk_in(0,0,0,2'b00,2'b11,0), mk_out(0,1,2'b00,0,0,1,0,1,5));
    add(mk_in(0,0,1,2'b00,2'b11,0), mk_out(0,1,2'b01,0,0,1,0,1,5));
    add(mk_in(0,0,0,2'b01,2'b11,0), mk_out(0,0,2'b00,0,0,0,0,1,5));
    add(mk_in(0,0,1,2'b11,2'b11,0), mk_out(0,0,2'b00,0,0,0,0,1,5));
    add(mk_in(0,1,0,2'b00,2'b11,0), mk_out(0,0,2'b00,0,0,0,0,1,5));
    add(mk_in(0,1,0,2'b00,2'b11,0), mk_out(0,1,2'b00,0,0,1,0,1,6));
    add(mk_in(1,1,1,2'b00,2'b11,0), mk_out(0,0,2'b00,0,0,0,0,1,6));
    add(mk_in(0,0,1,2'b00,2'b11,0), mk_out(0,0,2'b00,0,0,0,0,0,0));
    add(mk_in(0,1,0,2'b11,2'b11,0), mk_out(1,0,2'b00,1,1,0,0,0,0));
    add(mk_in(0,1,0,2'b01,2'b11,0), mk_out(1,0,2'b00,1,1,0,1,1,0));
    for (int k = 0; k < 18; k++)
      add(mk_in(0,1,0,2'b10,2'b11,0),
          mk_out(1,0,2'b00,1,0,0,1,((2+k) > 15) ? 15 : (2+k),0));
    add(mk_in(0,0,0,2'b00,2'b11,0), mk_out(0,0,2'b00,0,0,0,1,15,0));
    add(mk_in(1,0,0,2'b00,2'b11,0), mk_out(0,0,2'b00,0,0,0,1,15,0));
    add(mk_in(0,0,0,2'b00,2'b11,0), mk_out(0,0,2'b00,0,0,0,0,0,0));

    rst = 1'b1; mem_read = 1'b0; pmem_resp = 1'b0;
    hit_datapath = 2'b00; valid_out = 2'b00; lru_output = 1'b0;
    repeat (2) @(posedge clk);

    @(negedge clk);
    begin
      out_t ract, rexp;
      ract = sample();
      rexp = mk_out(0,0,2'b00,0,0,0,0,0,0);
      checks++;
      if (ract !== rexp) begin
        errors++;
        $display("FAIL reset state: got resp=%b pread=%b we=%b%b lt=%b lv=%b sv=%b ll=%b sl=%b das=%b err=%b hc=%0d mc=%0d",
                 ract.resp, ract.pread, ract.we1, ract.we0, ract.lt, ract.lv, ract.sv,
                 ract.ll, ract.sl, ract.das, ract.err, ract.hc, ract.mc);
      end
    end

    foreach (vecs[n]) begin
      out_t act, exp;
      @(posedge clk);
      #1;
      rst          = vecs[n].i.rst;
      mem_read     = vecs[n].i.mr;
      pmem_resp    = vecs[n].i.pr;
      hit_datapath = vecs[n].i.hit;
      valid_out    = vecs[n].i.valid;
      lru_output   = vecs[n].i.lru;
      exp_q.push_back(vecs[n].o);
      @(negedge clk);
      act = sample();
      exp = exp_q.pop_front();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL vec %0d: got resp=%b pread=%b we=%b%b lt=%b lv=%b sv=%b ll=%b sl=%b das=%b err=%b hc=%0d mc=%0d, want resp=%b pread=%b we=%b%b lt=%b lv=%b sv=%b ll=%b sl=%b das=%b err=%b hc=%0d mc=%0d",
                 n, act.resp, act.pread, act.we1, act.we0, act.lt, act.lv, act.sv,
                 act.ll, act.sl, act.das, act.err, act.hc, act.mc,
                 exp.resp, exp.pread, exp.we1, exp.we0, exp.lt, exp.lv, exp.sv,
                 exp.ll, exp.sl, exp.das, exp.err, exp.hc, exp.mc);
      end
    end

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_control.md
# icache_control

Sequencing FSM for the two-way, eight-set instruction-cache datapath.
- Decides hit or miss for each CPU read and returns hits in the same cycle.
- On a miss, picks a victim way and holds `pmem_read` until memory answers, then writes data, tag and valid in one cycle and replays the lookup to respond.
- Sits between the CPU fetch port, the cache datapath and the physical-memory port; also keeps saturating hit/miss counters and a sticky multi-hit error flag.

## Interface
Parameters:
- `CNT_WIDTH`, 32, width of the hit/miss performance counters.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_read` in 1: CPU read request, held until `mem_resp`.
- `mem_resp` out 1: CPU read complete; read data is valid on the datapath output this cycle.
- `pmem_resp` in 1: physical memory has `pmem_rdata` valid this cycle.
- `pmem_read` out 1: line-fill read request to physical memory.
- `hit_datapath` in 2: per-way tag match from the datapath, bit i = way i.
- `valid_out` in 2: valid bits of the indexed set.
- `lru_output` in 1: LRU way of the indexed set.
- `write_enable_0`, `write_enable_1` out 1 each: data-array load, way 0 / way 1.
- `load_tag` out 2: tag-array load per way.
- `load_valid` out 2: valid-array load per way.
- `set_valid` out 2: valid value written per way; always equals `load_valid`.
- `load_lru` out 1: LRU-array load.
- `set_lru` out 1: LRU value written, the way *not* just used.
- `data_array_select` out 1: fill-source select; 1 in FETCH, else 0.
- `hit_count` out CNT_WIDTH: first-lookup hits.
- `miss_count` out CNT_WIDTH: misses.
- `err_multi_hit` out 1: sticky flag set if `hit_datapath==2'b11` is ever seen while `mem_read`=1.

## Operation
- States: IDLE, FETCH, RESPOND. Reset value is IDLE.
- All array-control outputs, `pmem_read` and `mem_resp` default to 0. They are Moore/Mealy on the current state and inputs only.

IDLE, `mem_read`=1, hit (`hit_datapath` is 01 or 10):
- `mem_resp`=1 and `load_lru`=1 combinationally.
- `set_lru` = 1 on a way-0 hit, 0 on a way-1 hit.
- `hit_count` increments; state stays IDLE.

IDLE, `mem_read`=1, `hit_datapath`=00:
- `miss_count` increments.
- Victim is latched into a `victim` register:
  - way 0 if `valid_out[0]`=0;
  - else way 1 if `valid_out[1]`=0;
  - else `lru_output`.
- Next state is FETCH.

IDLE, `hit_datapath`=11 with `mem_read`=1:
- `err_multi_hit` is set; the request is treated as a way-0 hit.

FETCH:
- `pmem_read`=1 and `data_array_select`=1; `hit_datapath` is ignored.
- While `pmem_resp`=0, stay in FETCH.
- On the `pmem_resp`=1 cycle, for the victim way: `write_enable_<victim>`=1, `load_tag[victim]`=1, `load_valid[victim]`=1, `set_valid[victim]`=1. Next state is RESPOND.

RESPOND:
- The datapath now hits on the filled way.
- If `mem_read`=1: `mem_resp`=1, `load_lru`=1, `set_lru` = ~victim. No counter increments.
- Always returns to IDLE.

Counters:
- Unsigned, saturating at all-ones (no wrap); reset to 0.
- `err_multi_hit` is cleared only by `rst`.

Boundary cases:
- `mem_read` dropped during FETCH: the fill still completes (the memory transaction is never aborted); RESPOND gives no `mem_resp`.
- `rst` mid-FETCH: state goes to IDLE at that edge and `pmem_read` is 0 the following cycle. No array loads occur in the reset cycle; all outputs are forced to defaults while `rst`=1.
- `pmem_resp` asserted outside FETCH: ignored.

## Timing
- Hit latency is 0 cycles: `mem_resp` is in the same cycle as `mem_read` in IDLE.
- Miss: the request cycle is T.
  - FETCH begins at T+1 and `pmem_read` rises at T+1.
  - If `pmem_resp` arrives at T+1+k (k≥0), arrays load at the end of that cycle.
  - `mem_resp` is at T+2+k; IDLE resumes at T+3+k.
- Back-to-back hits give one `mem_resp` per cycle.
- The CPU holds the address stable until `mem_resp`.

## Test plan
- Reset, then cold read of 0x0000_0040 with `pmem_resp` 3 cycles into FETCH → `pmem_read` high 4 cycles; `write_enable_0`, `load_tag`=01, `load_valid`=01 for 1 cycle; `mem_resp` at T+5; `miss_count`=1, `hit_count`=0.
- Same address again with `hit_datapath`=01 → `mem_resp` same cycle, `load_lru`=1, `set_lru`=1; `hit_count`=1.
- Set full, `valid_out`=11, `lru_output`=1, miss → way 1 filled (`write_enable_1`, `load_tag`=10); RESPOND `set_lru`=0.
- `mem_read` dropped 2 cycles into FETCH → fill completes on `pmem_resp`; no `mem_resp`; back to IDLE.
- `rst` asserted mid-FETCH → next cycle state IDLE, `pmem_read`=0, counters 0, no array loads.
- `hit_datapath`=11 with `mem_read`=1 → `err_multi_hit`=1 and stays 1 until `rst`. Force `hit_count` to all-ones, then hit → count stays all-ones.
